// File: rtl/mul_div_unit_pkg.sv
// Shared opcode encoding, FSM state type and helpers for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam int MDOP_SIZE = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [MDOP_SIZE-1:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6,
    MDOP_MFHI  = 4'd7,
    MDOP_MFLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mul(input logic [MDOP_SIZE-1:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  function automatic logic is_div(input logic [MDOP_SIZE-1:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_md_arith.sv
// Combinational arithmetic for the MDU: signed/unsigned 32x32 multiply and divide.
module md_arith
  import mul_div_unit_pkg::*;
(
  input  logic [MDOP_SIZE-1:0] op_i,
  input  logic [31:0]          a_i,
  input  logic [31:0]          b_i,
  output logic [63:0]          result_o,
  output logic                 div_by_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  // Signed divide runs on magnitudes and fixes signs afterwards; this also
  // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  always_comb begin
    signed_div = (op_i == MDOP_DIV);
    dividend   = (signed_div && a_i[31]) ? (32'd0 - a_i) : a_i;
    divisor    = (signed_div && b_i[31]) ? (32'd0 - b_i) : b_i;
    if (b_i == 32'd0) begin
      divisor = 32'd1;
    end
    uquot = dividend / divisor;
    urem  = dividend % divisor;
    quot  = uquot;
    rem   = urem;
    if (signed_div) begin
      quot = (a_i[31] ^ b_i[31]) ? (32'd0 - uquot) : uquot;
      rem  = a_i[31] ? (32'd0 - urem) : urem;
    end
  end

  always_comb begin
    result_o      = 64'd0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MDOP_MULT:  result_o = prod_s;
      MDOP_MULTU: result_o = prod_u;
      MDOP_DIV, MDOP_DIVU: begin
        result_o      = {rem, quot};
        div_by_zero_o = (b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy sequencer,
// and the stall request that holds MDU instructions in D while busy.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 E_md_start,
  input  logic [MDOP_SIZE-1:0] E_md_op,
  input  logic [31:0]          E_operand1,
  input  logic [31:0]          E_operand2,
  input  logic                 D_md_use,
  output logic                 md_busy,
  output logic                 md_stall,
  output logic [31:0]          md_read_data,
  output logic [31:0]          HI,
  output logic [31:0]          LO,
  output logic                 md_state_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             dbz_q, dbz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_res;
  logic             arith_dbz;
  logic             start_muldiv;

  md_arith u_arith (
    .op_i          (E_md_op),
    .a_i           (E_operand1),
    .b_i           (E_operand2),
    .result_o      (arith_res),
    .div_by_zero_o (arith_dbz)
  );

  assign start_muldiv = E_md_start && (is_mul(E_md_op) || is_div(E_md_op));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Handshake: a mult/div start is accepted only in IDLE; the hazard
  // controller never issues one while md_busy, and one that slips through is
  // dropped. Completion writes HI/LO after any same-cycle mthi/mtlo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (E_md_start && (E_md_op == MDOP_MTHI)) hi_d = E_operand1;
    if (E_md_start && (E_md_op == MDOP_MTLO)) lo_d = E_operand1;

    case (state_q)
      ST_IDLE: begin
        if (start_muldiv) begin
          state_d = ST_BUSY;
          cnt_d   = is_mul(E_md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          res_d   = arith_res;
          dbz_d   = arith_dbz;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!dbz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md_read_data = 32'd0;
    case (E_md_op)
      MDOP_MFHI: md_read_data = hi_q;
      MDOP_MFLO: md_read_data = lo_q;
      default:   ;
    endcase
  end

  assign md_busy    = (state_q == ST_BUSY);
  assign md_stall   = D_md_use && (md_busy || start_muldiv);
  assign HI         = hi_q;
  assign LO         = lo_q;
  assign md_state_o = state_q;

  start_while_busy_a: assert property (@(posedge clk) disable iff (reset)
    !(md_busy && start_muldiv));

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected completions are queued at issue
// and compared by a monitor when md_busy falls.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 E_md_start;
  logic [MDOP_SIZE-1:0] E_md_op;
  logic [31:0]          E_operand1;
  logic [31:0]          E_operand2;
  logic                 D_md_use;
  logic                 md_busy;
  logic                 md_stall;
  logic [31:0]          md_read_data;
  logic [31:0]          HI;
  logic [31:0]          LO;
  logic                 md_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {busy_cycles[7:0], hi[31:0], lo[31:0]}
  logic [71:0] exp_q[$];
  logic [71:0] exp_item;
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_md_start   (E_md_start),
    .E_md_op      (E_md_op),
    .E_operand1   (E_operand1),
    .E_operand2   (E_operand2),
    .D_md_use     (D_md_use),
    .md_busy      (md_busy),
    .md_stall     (md_stall),
    .md_read_data (md_read_data),
    .HI           (HI),
    .LO           (LO),
    .md_state_o   (md_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (md_busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("busy_cycles", 32'(busy_cnt), {24'd0, exp_item[71:64]});
          check("hi_result", HI, exp_item[63:32]);
          check("lo_result", LO, exp_item[31:0]);
        end
        busy_cnt = 0;
      end
      prev_busy = md_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [MDOP_SIZE-1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    E_md_start = (op != MDOP_NONE);
    E_md_op    = op;
    E_operand1 = a;
    E_operand2 = b;
    @(posedge clk); #2;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (md_busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [MDOP_SIZE-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] cycles, input logic [31:0] hi, input logic [31:0] lo);
    exp_q.push_back({cycles, hi, lo});
    issue(op, a, b);
    wait_idle();
  endtask

  task automatic read_check(input logic [MDOP_SIZE-1:0] op, input string name, input logic [31:0] exp);
    @(posedge clk); #2;
    E_md_start = 1'b1;
    E_md_op    = op;
    @(negedge clk);
    check(name, md_read_data, exp);
    @(posedge clk); #2;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall_cnt;
    reset      = 1'b1;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
    E_operand1 = '0;
    E_operand2 = '0;
    D_md_use   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_read", md_read_data, 32'd0);
    check("reset_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    run_op(MDOP_MULT,  32'hFFFFFFFE, 32'd3, 8'd5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    read_check(MDOP_MFHI, "mfhi_after_mult", 32'hFFFFFFFF);
    read_check(MDOP_MFLO, "mflo_after_mult", 32'hFFFFFFFA);
    run_op(MDOP_MULTU, 32'hFFFFFFFF, 32'd2, 8'd5, 32'h00000001, 32'hFFFFFFFE);
    run_op(MDOP_MULT,  32'h80000000, 32'h80000000, 8'd5, 32'h40000000, 32'h00000000);
    run_op(MDOP_DIV,   32'hFFFFFFF9, 32'd2, 8'd10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(MDOP_DIVU,  32'd7, 32'd0, 8'd10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(MDOP_DIV,   32'h80000000, 32'hFFFFFFFF, 8'd10, 32'h00000000, 32'h80000000);
    run_op(MDOP_DIVU,  32'd100, 32'd7, 8'd10, 32'd2, 32'd14);
    run_op(MDOP_DIV,   32'd7, 32'hFFFFFFFE, 8'd10, 32'd1, 32'hFFFFFFFD);

    // Stall with D_md_use held: start cycle plus every busy cycle.
    exp_q.push_back({8'd10, 32'd2, 32'd6});
    @(posedge clk); #2;
    D_md_use   = 1'b1;
    E_md_start = 1'b1;
    E_md_op    = MDOP_DIV;
    E_operand1 = 32'd20;
    E_operand2 = 32'd3;
    @(negedge clk);
    check("stall_start_cycle", {31'd0, md_stall}, 32'd1);
    @(posedge clk); #2;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
    stall_cnt  = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!md_stall) break;
      stall_cnt++;
    end
    check("stall_busy_cycles", 32'(stall_cnt), 32'd10);
    check("stall_released", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #2;
    D_md_use = 1'b0;

    // No stall when D holds no MDU op.
    exp_q.push_back({8'd10, 32'd0, 32'd5});
    stall_cnt = 0;
    @(posedge clk); #2;
    E_md_start = 1'b1;
    E_md_op    = MDOP_DIVU;
    E_operand1 = 32'd15;
    E_operand2 = 32'd3;
    @(negedge clk);
    if (md_stall) stall_cnt++;
    @(posedge clk); #2;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (md_stall) stall_cnt++;
      if (!md_busy) break;
    end
    check("no_stall_without_d_use", 32'(stall_cnt), 32'd0);

    // mtlo / mthi / mflo / mfhi
    @(posedge clk); #2;
    E_md_start = 1'b1;
    E_md_op    = MDOP_MTLO;
    E_operand1 = 32'h000000AA;
    @(posedge clk); #2;
    E_md_op    = MDOP_MTHI;
    E_operand1 = 32'h12345678;
    @(posedge clk); #2;
    E_md_op    = MDOP_MFLO;
    @(negedge clk);
    check("mthi_hi", HI, 32'h12345678);
    check("mtlo_lo", LO, 32'h000000AA);
    check("mthi_no_busy", {31'd0, md_busy}, 32'd0);
    check("mflo_read", md_read_data, 32'h000000AA);
    @(posedge clk); #2;
    E_md_op = MDOP_MFHI;
    @(negedge clk);
    check("mfhi_read", md_read_data, 32'h12345678);
    @(posedge clk); #2;
    E_md_start = 1'b0;
    E_md_op    = MDOP_NONE;
    @(negedge clk);
    check("read_none", md_read_data, 32'd0);

    // Reset in the third busy cycle of a mult aborts it.
    issue(MDOP_MULT, 32'd5, 32'd7);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, md_busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_late_busy", {31'd0, md_busy}, 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
